// File: rtl/dna_pkg.sv
// Shared types for the DNA loader and search machine: nucleotide codes,
// loader FSM states and packing geometry.
package dna_pkg;

    localparam int unsigned NUCS_PER_WORD = 8;
    localparam int unsigned NUC_W         = 2;
    localparam int unsigned LEN_W         = 16;

    typedef enum logic [1:0] {
        NUC_A = 2'b00,
        NUC_C = 2'b01,
        NUC_G = 2'b10,
        NUC_T = 2'b11
    } nucleotide_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/ascii2nuc.sv
// Combinational ASCII to 2-bit nucleotide decoder; accepts upper and lower case.
module ascii2nuc
    import dna_pkg::*;
(
    input  logic [7:0]       ch,
    output logic             nuc_ok_c,
    output logic [NUC_W-1:0] nuc_c
);

    nucleotide_t nuc;

    always_comb begin
        nuc_ok_c = 1'b1;
        nuc      = NUC_A;
        case (ch)
            8'h41, 8'h61: nuc = NUC_A;
            8'h43, 8'h63: nuc = NUC_C;
            8'h47, 8'h67: nuc = NUC_G;
            8'h54, 8'h74: nuc = NUC_T;
            default:      nuc_ok_c = 1'b0;
        endcase
    end

    assign nuc_c = nuc;

endmodule

// File: rtl/dna_loader.sv
// Streams ASCII nucleotides in, packs them MSB-first into memory words at
// consecutive addresses and reports the accepted nucleotide count.
module dna_loader
    import dna_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORD_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              char_valid,
    input  logic [7:0]        char_in,
    input  logic              char_last,
    output logic              char_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [LEN_W-1:0]  dna_length,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned       SLOT_W    = $clog2(NUCS_PER_WORD);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUCS_PER_WORD - 1);

    loader_state_t     state, state_nxt;
    logic [SLOT_W-1:0] slot;
    logic [WORD_W-1:0] pack;
    logic [ADDR_W-1:0] word_addr;

    logic              nuc_ok_c;
    logic [NUC_W-1:0]  nuc_c;
    logic              start_c, accept_c, fault_c, take_c, close_c;
    logic [SLOT_W:0]   shamt_c;
    logic [WORD_W-1:0] word_c;

    ascii2nuc u_ascii2nuc (
        .ch       (char_in),
        .nuc_ok_c (nuc_ok_c),
        .nuc_c    (nuc_c)
    );

    // Next state plus per-cycle accept/fault/close decisions
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        accept_c  = 1'b0;
        fault_c   = 1'b0;
        take_c    = 1'b0;
        close_c   = 1'b0;
        shamt_c   = {SLOT_LAST - slot, 1'b0};
        word_c    = pack | (WORD_W'(nuc_c) << shamt_c);
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    start_c   = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                accept_c = char_valid & char_ready;
                if (accept_c) begin
                    // Bad byte or a char beyond the max count aborts; partial word dropped
                    fault_c = !nuc_ok_c || (dna_length == '1);
                    take_c  = !fault_c;
                    close_c = take_c && (char_last || (slot == SLOT_LAST));
                    if (fault_c)
                        state_nxt = ST_ERR;
                    else if (char_last)
                        state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot       <= '0;
            pack       <= '0;
            word_addr  <= '0;
            dna_length <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            char_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we     <= close_c;
            char_ready <= (state_nxt == ST_LOAD);
            busy       <= (state_nxt == ST_LOAD) || (state_nxt == ST_FLUSH);
            done       <= (state_nxt == ST_DONE);
            error      <= (state_nxt == ST_ERR);
            if (start_c) begin
                slot       <= '0;
                pack       <= '0;
                dna_length <= '0;
                word_addr  <= base_addr;
            end
            if (take_c) begin
                dna_length <= dna_length + 1'b1;
                if (close_c) begin
                    mem_addr  <= word_addr;
                    mem_wdata <= word_c;
                    word_addr <= word_addr + 1'b1;
                    pack      <= '0;
                    slot      <= '0;
                end else begin
                    pack <= word_c;
                    slot <= slot + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dna_loader.sv
// Self-checking bench for dna_loader: directed loads against a queue-based
// reference model of the expected memory writes and final status.
module tb_dna_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_last = 1'b0;
    logic        char_ready, mem_we, busy, done, error;
    logic [15:0] mem_addr, mem_wdata, dna_length;

    int  n_chk = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t mon_w;
    int  exp_len;
    bit  exp_err;
    bq_t q;

    always #5 clock = ~clock;

    dna_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .char_valid (char_valid),
        .char_in    (char_in),
        .char_last  (char_last),
        .char_ready (char_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dna_length (dna_length),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int enc(input logic [7:0] c);
        case (c)
            "A", "a": return 0;
            "C", "c": return 1;
            "G", "g": return 2;
            "T", "t": return 3;
            default:  return -1;
        endcase
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t r;
        for (int i = 0; i < s.len(); i++) r.push_back(s[i]);
        return r;
    endfunction

    // Reference: encode until first bad char or count limit, then cut into 8-nucleotide words
    task automatic build_model(input bq_t chars, input logic [15:0] base, input bit last_en);
        int codes[$];
        bit bad;
        int nw;
        logic [15:0] d;
        bad = 1'b0;
        foreach (chars[i]) begin
            if (enc(chars[i]) < 0 || codes.size() == 65535) begin
                bad = 1'b1;
                break;
            end
            codes.push_back(enc(chars[i]));
        end
        exp_len = codes.size();
        exp_err = bad;
        nw = (last_en && !bad) ? (codes.size() + 7) / 8 : codes.size() / 8;
        exp_q.delete();
        for (int k = 0; k < nw; k++) begin
            d = '0;
            for (int j = 0; j < 8; j++)
                if (8 * k + j < codes.size()) d = d | (16'(codes[8 * k + j]) << (14 - 2 * j));
            exp_q.push_back({base + 16'(k), d});
        end
    endtask

    // Every memory write must match the next expected one
    always @(negedge clock) begin
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(mon_w.addr));
                check("write_data", 64'(mem_wdata), 64'(mon_w.data));
            end
        end
    end

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        to_drive();
    endtask

    task automatic do_start(input logic [15:0] base);
        base_addr = base;
        start = 1'b1;
        to_drive();
        start = 1'b0;
    endtask

    task automatic send(input bq_t chars, input bit gap, input bit last_en);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < chars.size()) begin
            char_valid = gap ? ((cyc % 2) == 0) : 1'b1;
            char_in    = chars[i];
            char_last  = last_en && (i == chars.size() - 1);
            @(negedge clock);
            acc = char_valid && char_ready;
            to_drive();
            if (acc) i++;
            cyc++;
            if (cyc > 2 * chars.size() + 20) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got %0d accepted expected %0d", i, chars.size());
                break;
            end
        end
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        @(negedge clock);
        while (!(done || error) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({name, "_finished"}, 64'(done || error), 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        to_drive();
        do_reset();

        // Reset state
        @(negedge clock);
        check("reset_outputs", 64'({char_ready, mem_we, busy, done, error, mem_addr, mem_wdata, dna_length}), 64'd0);
        to_drive();

        // Full word, exact done timing
        q = str2q("ACGTACGT");
        build_model(q, 16'h0001, 1'b1);
        check("model_fullword", 64'(exp_q[0].data), 64'h1B1B);
        do_start(16'h0001);
        check("start_ready", 64'(char_ready), 64'd1);
        send(q, 1'b0, 1'b1);
        @(negedge clock);
        check("flush_we", 64'(mem_we), 64'd1);
        check("flush_not_done", 64'(done), 64'd0);
        @(negedge clock);
        check("full_done", 64'(done), 64'd1);
        check("full_len", 64'(dna_length), 64'd8);
        check("full_writes_left", 64'(exp_q.size()), 64'd0);
        to_drive();

        // Partial and multiword
        q.delete();
        for (int i = 0; i < 45; i++) q.push_back(str2q("GATTACA")[i % 7]);
        build_model(q, 16'h0001, 1'b1);
        check("model_multi_count", 64'(exp_q.size()), 64'd6);
        check("model_multi_w0", 64'(exp_q[0].data), 64'h8F12);
        check("model_multi_last", 64'(exp_q[5]), 64'h0006_48C0);
        do_start(16'h0001);
        send(q, 1'b0, 1'b1);
        wait_end("multi");
        check("multi_done", 64'({done, error}), 64'b10);
        check("multi_len", 64'(dna_length), 64'd45);
        check("multi_writes_left", 64'(exp_q.size()), 64'd0);
        to_drive();

        // Lowercase with gapped valid
        q = str2q("acgt");
        build_model(q, 16'h0040, 1'b1);
        check("model_lower", 64'(exp_q[0].data), 64'h1B00);
        do_start(16'h0040);
        send(q, 1'b1, 1'b1);
        wait_end("lower");
        check("lower_len", 64'(dna_length), 64'd4);
        check("lower_writes_left", 64'(exp_q.size()), 64'd0);
        to_drive();

        // Invalid character, then valid held while not ready
        q = str2q("ACGTACGTACN");
        build_model(q, 16'h0100, 1'b0);
        check("model_invalid", 64'({exp_q.size() == 1, exp_err, 16'(exp_len)}), 64'h3_000A);
        do_start(16'h0100);
        send(q, 1'b0, 1'b0);
        @(negedge clock);
        check("inv_flags", 64'({error, char_ready, busy}), 64'b100);
        check("inv_len", 64'(dna_length), 64'd10);
        to_drive();
        char_valid = 1'b1;
        char_in = "A";
        repeat (4) to_drive();
        char_valid = 1'b0;
        check("inv_hold_len", 64'(dna_length), 64'd10);
        check("inv_writes_left", 64'(exp_q.size()), 64'd0);
        do_start(16'h0200);
        @(negedge clock);
        check("restart_clears", 64'({error, done, char_ready}), 64'b001);
        to_drive();

        // Reset mid-load
        do_reset();
        exp_q.delete();
        do_start(16'h0300);
        send(str2q("ACGTA"), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_outputs", 64'({char_ready, mem_we, busy, done, error, mem_addr, mem_wdata, dna_length}), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) to_drive();
        check("midreset_idle", 64'({char_ready, busy, done, error}), 64'd0);

        // Address wrap
        q = str2q("ACGTACGTG");
        build_model(q, 16'hFFFF, 1'b1);
        check("model_wrap", 64'(exp_q[1]), 64'h0000_8000);
        do_start(16'hFFFF);
        send(q, 1'b0, 1'b1);
        wait_end("wrap");
        check("wrap_len", 64'(dna_length), 64'd9);
        check("wrap_writes_left", 64'(exp_q.size()), 64'd0);
        to_drive();

        // Length overflow on the 65536th char
        q.delete();
        for (int i = 0; i < 65536; i++) q.push_back(str2q("ACGT")[i % 4]);
        build_model(q, 16'h0000, 1'b0);
        check("model_ovf", 64'({16'(exp_q.size()), 16'(exp_len)}), 64'h1FFF_FFFF);
        do_start(16'h0000);
        send(q, 1'b0, 1'b0);
        @(negedge clock);
        check("ovf_flags", 64'({error, char_ready, done}), 64'b100);
        check("ovf_len", 64'(dna_length), 64'd65535);
        check("ovf_writes_left", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dna_loader.md
# dna_loader

Upstream feeder for the DNA pattern-search machine. It accepts an ASCII nucleotide stream over a valid/ready handshake and encodes each character to a 2-bit code. Codes are packed MSB-first into 16-bit memory words and written to consecutive addresses from a base address. On completion it reports the nucleotide count, which the search stage consumes as its DNA length and start address.

## Interface
- ADDR_W, 16, memory address width
- WORD_W, 16, memory word width; holds WORD_W/2 = 8 nucleotides
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load (honoured in IDLE, DONE, ERR only)
- base_addr  in  ADDR_W  first word address; sampled on accepted start
- char_valid  in  1  char_in/char_last valid
- char_in  in  8  ASCII character
- char_last  in  1  marks final character of the sequence
- char_ready  out  1  loader accepts a character this cycle
- mem_we  out  1  write strobe, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  WORD_W  packed word
- dna_length  out  16  nucleotides accepted; valid while done=1
- busy  out  1  high in LOAD and FLUSH
- done  out  1  load complete, held until next start
- error  out  1  load aborted, held until next start

## Operation
- Encoding: 'A'/'a'=00, 'C'/'c'=01, 'G'/'g'=10, 'T'/'t'=11. Any other byte is invalid.
- Packing: the first nucleotide of a word goes in bits [15:14], the next in [13:12], and so on. Unused low bits of a partial final word are 0.
- Addressing: word k is written to base_addr + k, modulo 2^ADDR_W (wraps silently).
- A transfer is accepted when char_valid & char_ready.
- States:
  - IDLE: char_ready=0. start → LOAD; clears the nucleotide counter, packer, done and error.
  - LOAD: char_ready=1.
    - Valid char accepted: shift it in and increment the counter.
    - Word filled (8th slot) and not last: a write is issued the next cycle and LOAD continues.
    - Last char accepted (word full or partial): → FLUSH.
    - Invalid char accepted: → ERR; nothing written for the current word; earlier full words remain in memory.
    - Counter at 65535 and another valid char accepted: → ERR (overflow).
  - FLUSH: char_ready=0. The final word write is issued this cycle, then → DONE.
  - DONE: done=1, dna_length held. start → LOAD.
  - ERR: error=1, char_ready=0. dna_length holds the count of valid chars accepted before the fault. start → LOAD.
- start while busy is ignored.
- Reset values: state IDLE; char_ready, mem_we, busy, done, error = 0; mem_addr, mem_wdata, dna_length = 0.
- Reset mid-load: the partial word is discarded and no further writes occur.

## Timing
- mem_we, mem_addr and mem_wdata are registered. A write appears in cycle t+1 when the accept that closed the word occurs in cycle t.
- For a full non-last word, LOAD keeps accepting in cycle t+1 with no bubble. Sustained rate is 1 char/cycle.
- Last char accepted in cycle t: final write in cycle t+1 (FLUSH), done=1 from cycle t+2.
- Invalid char accepted in cycle t: error=1 and char_ready=0 from cycle t+1; mem_we=0 from t+1 onward. A pending full-word write from cycle t−1's accept still completes in cycle t.
- Accepted start in cycle t: char_ready=1 from cycle t+1; done and error drop in cycle t+1.
- Minimum sequence is 1 char (char_last on the first accept), giving one write with wdata = code<<14.
- char_valid while char_ready=0 has no effect; the source holds its data.

## Structure
- Shared package dna_pkg:
  - nucleotide_t (2-bit enum A/C/G/T);
  - loader state enum (IDLE, LOAD, FLUSH, DONE, ERR);
  - NUCS_PER_WORD = 8.
- This package is also imported by the search machine for nucleotide decode.
- Sub-module ascii2nuc: combinational character → {valid, nucleotide_t} decoder.
- Top module contains the FSM, 3-bit slot counter, 16-bit length counter, shift/pack register, word-address counter and output registers.

## Test plan
- Full word: start, base_addr=0x0001, stream "ACGTACGT" with last on the 8th char → one write at 0x0001 of 0x1B1B; done=1 two cycles after the last accept; dna_length=8.
- Partial and multiword: base_addr=0x0001, 45 chars of "GATTACA" repeated → writes at 0x0001..0x0006; the final word holds 5 nucleotides with bits [5:0]=0; dna_length=45.
- Lowercase and backpressure: "acgt" with char_valid toggling every other cycle → single write 0x1B00; dna_length=4; no accept occurs while char_ready=0.
- Invalid char: "ACGTACGTAC" then 'N' → one write 0x1B1B at base, no second write; error=1, dna_length=10, char_ready=0; a new start clears error.
- Reset mid-load: assert reset after 5 chars → all outputs 0 in the same cycle, no write; state is IDLE after release.
- Wrap and overflow: base_addr=0xFFFF with 9 chars → writes at 0xFFFF then 0x0000. A separate run of 65536 chars → error on the 65536th, dna_length=65535.
